// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 arrow-key tracker.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [15:0] KEY_LEFT  = 16'hE06B;
    localparam logic [15:0] KEY_DOWN  = 16'hE072;
    localparam logic [15:0] KEY_RIGHT = 16'hE074;
    localparam logic [15:0] KEY_UP    = 16'hE075;

    // One-hot arrow vector ordering is {left, down, right, up}.
    localparam logic [3:0] ARW_LEFT  = 4'b1000;
    localparam logic [3:0] ARW_DOWN  = 4'b0100;
    localparam logic [3:0] ARW_RIGHT = 4'b0010;
    localparam logic [3:0] ARW_UP    = 4'b0001;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_arrow_decode.sv
// Combinational map from a 16-bit scan code to a one-hot arrow-key vector.
module ps2_arrow_decode
    import ps2_pkg::*;
(
    input  logic [15:0] code_i,
    output logic [3:0]  arrow_o
);

    // Arrow lookup; non-arrow codes decode to zero.
    always_comb begin
        arrow_o = 4'b0000;
        case (code_i)
            KEY_LEFT:  arrow_o = ARW_LEFT;
            KEY_DOWN:  arrow_o = ARW_DOWN;
            KEY_RIGHT: arrow_o = ARW_RIGHT;
            KEY_UP:    arrow_o = ARW_UP;
            default:   arrow_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ps2_arrow_tracker.sv
// Assembles PS/2 set-2 bytes into make/break events and tracks arrow-key levels,
// with a watchdog that abandons truncated prefix sequences.
module ps2_arrow_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        code_valid,
    output logic        is_break,
    output logic [15:0] scancode,
    output logic        err,
    output logic        left,
    output logic        down,
    output logic        right,
    output logic        up
);

    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT);

    ps2_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  cnt_inc_s;
    logic           timeout_s;

    logic           emit_s, emit_brk_s, emit_ext_s, err_s;
    logic [15:0]    emit_code_s;
    logic [3:0]     arrow_hit_s;
    logic [3:0]     arrows_d, arrows_q;

    logic           code_valid_q, is_break_q, err_q;
    logic [15:0]    scancode_q;

    // Saturating increment; expiry fires on the cycle the count would reach TIMEOUT.
    always_comb begin
        if (cnt_q == TMAX) begin
            cnt_inc_s = cnt_q;
        end else begin
            cnt_inc_s = cnt_q + CW'(1);
        end
        timeout_s = (state_q != ST_IDLE) && !byte_valid && (cnt_inc_s >= TMAX);
    end

    // Sequencer state and watchdog counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; an accepted byte always wins over a coincident expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (byte_valid) begin
            cnt_d = {CW{1'b0}};
            case (state_q)
                ST_IDLE: begin
                    if (byte_data == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else if (byte_data == PS2_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (byte_data == PS2_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (byte_data == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK:     state_d = ST_IDLE;
                ST_EXT_BRK: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end else if (state_q == ST_IDLE) begin
            cnt_d = {CW{1'b0}};
        end else if (timeout_s) begin
            state_d = ST_IDLE;
            cnt_d   = {CW{1'b0}};
        end else begin
            cnt_d = cnt_inc_s;
        end
    end

    // Emission and error decisions for the current cycle.
    always_comb begin
        emit_s     = 1'b0;
        emit_brk_s = 1'b0;
        emit_ext_s = 1'b0;
        err_s      = 1'b0;
        if (byte_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_prefix(byte_data)) begin
                        emit_s = 1'b0;
                    end else begin
                        emit_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (is_prefix(byte_data)) begin
                        emit_s = 1'b0;
                    end else begin
                        emit_s     = 1'b1;
                        emit_ext_s = 1'b1;
                    end
                end
                ST_BRK: begin
                    if (is_prefix(byte_data)) begin
                        err_s = 1'b1;
                    end else begin
                        emit_s     = 1'b1;
                        emit_brk_s = 1'b1;
                    end
                end
                ST_EXT_BRK: begin
                    if (is_prefix(byte_data)) begin
                        err_s = 1'b1;
                    end else begin
                        emit_s     = 1'b1;
                        emit_brk_s = 1'b1;
                        emit_ext_s = 1'b1;
                    end
                end
                default: err_s = 1'b0;
            endcase
        end else if (timeout_s) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    assign emit_code_s = {(emit_ext_s ? PS2_EXT : 8'h00), byte_data};

    ps2_arrow_decode u_decode (
        .code_i  (emit_code_s),
        .arrow_o (arrow_hit_s)
    );

    // Held levels: makes set, breaks clear, everything else holds.
    always_comb begin
        if (!emit_s) begin
            arrows_d = arrows_q;
        end else if (emit_brk_s) begin
            arrows_d = arrows_q & ~arrow_hit_s;
        end else begin
            arrows_d = arrows_q | arrow_hit_s;
        end
    end

    // Registered outputs; scancode and is_break only move on an emission.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
            is_break_q   <= 1'b0;
            scancode_q   <= 16'h0000;
            arrows_q     <= 4'b0000;
        end else begin
            code_valid_q <= emit_s;
            err_q        <= err_s;
            arrows_q     <= arrows_d;
            if (emit_s) begin
                scancode_q <= emit_code_s;
                is_break_q <= emit_brk_s;
            end else begin
                scancode_q <= scancode_q;
                is_break_q <= is_break_q;
            end
        end
    end

    assign code_valid = code_valid_q;
    assign err        = err_q;
    assign is_break   = is_break_q;
    assign scancode   = scancode_q;
    assign left       = arrows_q[3];
    assign down       = arrows_q[2];
    assign right      = arrows_q[1];
    assign up         = arrows_q[0];

endmodule

// File: doc/ps2_arrow_tracker.md
# ps2_arrow_tracker

Assembles single-byte PS/2 set-2 scan codes from a byte-level receiver into complete make/break events, including E0-extended and F0-break sequences. Maintains a held/released level for the four arrow keys. Sits between the PS/2 byte receiver and game/control logic, which consume either the event stream or the held levels. A prefix-timeout watchdog recovers the sequencer when a multi-byte sequence is truncated.

## Interface
Parameters:
- `TIMEOUT`, default 1000: cycles without a new byte, after a prefix byte, before the sequence is abandoned; must be ≥ 1.

Ports:
- `clk`  in  1  — single clock; all state is updated on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `byte_valid`  in  1  — one-cycle strobe; `byte_data` is accepted in this cycle.
- `byte_data`  in  8  — received PS/2 byte.
- `code_valid`  out  1  — one-cycle pulse when a complete code has been assembled.
- `is_break`  out  1  — qualifies `code_valid`: 1 = release, 0 = press.
- `scancode`  out  16  — last completed code: `{8'hE0, b}` for extended codes, `{8'h00, b}` otherwise; holds until the next event.
- `err`  out  1  — one-cycle pulse on a protocol error or timeout.
- `left`  out  1  — held level for the left arrow key (`16'hE06B`).
- `down`  out  1  — held level for the down arrow key (`16'hE072`).
- `right`  out  1  — held level for the right arrow key (`16'hE074`).
- `up`  out  1  — held level for the up arrow key (`16'hE075`).

## Operation
States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions on an accepted byte `b`:
- **IDLE:**
  - `E0` → EXT.
  - `F0` → BRK.
  - Any other `b`: emit make `{00,b}`; stay in IDLE.
- **EXT:**
  - `F0` → EXT_BRK.
  - `E0`: stay in EXT, no error; the timeout counter restarts.
  - Any other `b`: emit make `{E0,b}`; → IDLE.
- **BRK:**
  - `E0` or `F0`: pulse `err`, no emission; → IDLE.
  - Any other `b`: emit break `{00,b}`; → IDLE.
- **EXT_BRK:**
  - `E0` or `F0`: pulse `err`, no emission; → IDLE.
  - Any other `b`: emit break `{E0,b}`; → IDLE.

Emission:
- `scancode`, `is_break` and the `code_valid` pulse are all updated together.

Held levels:
- A make of an arrow code sets that key's flag; a break clears it.
- All other codes leave the flags unchanged.
- Repeated makes (typematic) keep the flag at 1.
- More than one flag may be 1 at the same time.

Timeout:
- A cycle counter runs only in non-IDLE states.
- It is cleared on every accepted byte.
- When it reaches `TIMEOUT` with no byte accepted: go to IDLE, pulse `err`, emit nothing, leave the held levels unchanged.
- Counter width is `$clog2(TIMEOUT+1)`; the counter saturates and never wraps.

Reset:
- All outputs 0; `scancode = 16'h0000`; state = IDLE; counter = 0.
- Reset asserted in the middle of a sequence discards the partial sequence.

## Timing
- **Latency:** a byte accepted at cycle t produces `code_valid`/`err`, the new `scancode`/`is_break` and the held levels at the outputs in cycle t+1. All outputs are registered.
- **Back-to-back bytes:** `byte_valid` may be asserted on consecutive cycles; every byte is accepted and there is no stall.
- **Timeout:** prefix accepted at t, no `byte_valid` in cycles t+1 … t+`TIMEOUT` → `err` = 1 in cycle t+`TIMEOUT`+1 and state = IDLE. A byte arriving exactly at t+`TIMEOUT` is processed normally and no timeout occurs.
- **Simultaneous events:** when the timeout expiry and `byte_valid` fall in the same cycle, the byte takes priority.
- **Pulses:** `code_valid` and `err` are never asserted in the same cycle.

## Structure
- **`ps2_pkg`:**
  - State enum `ps2_state_t`.
  - Constants `PS2_EXT = 8'hE0` and `PS2_BRK = 8'hF0`.
  - Arrow key codes `KEY_LEFT`, `KEY_DOWN`, `KEY_RIGHT`, `KEY_UP`.
- **Sub-module `ps2_arrow_decode`:** purely combinational; maps a 16-bit code to a 4-bit one-hot arrow vector. Each of its outputs is assigned on every path, so it infers no latches. The tracker uses it to drive the set/clear of the held levels.

## Test plan
1. Reset pulsed asynchronously between clock edges → all outputs 0 immediately; a subsequent `E0 75` → `up` = 1, `code_valid` pulse with `scancode = E075`, `is_break` = 0.
2. `E0 6B`, then `E0 F0 6B` → `left` 1 then 0. The second event reports `scancode = E06B` with `is_break` = 1.
3. Non-extended `1C`, then `F0 1C` → `scancode = 001C` make then break; all arrow levels stay at 0.
4. `E0` alone with `TIMEOUT` = 8, idle for 8 cycles → `err` pulses in cycle 9 after the `E0`. A following `72` is then treated as make `0072`, and `down` stays 0.
5. `F0 E0` → `err` pulse, no `code_valid`, state returns to IDLE; the next `E0 74` → `right` = 1.
6. `E0 6B`, `E0 72` sent back-to-back (`byte_valid` held high for 4 cycles) → two `code_valid` pulses; `left` and `down` both 1.
